// File: rtl/pulse_sync_pkg.sv
// pulse_sync_pkg: shared types, defaults and helpers for the pulse scheduler
package pulse_sync_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;
  localparam int DEF_REQ = 4;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP = 6;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/pulse_sync_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending bit at or after rr_ptr
module rr_arbiter
  import pulse_sync_pkg::*;
#(
  parameter int pREQ = DEF_REQ,
  localparam int ID_W = clog2(pREQ)
) (
  input  logic [pREQ-1:0] pend,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [pREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);
  always_comb begin
    gnt_id = '0;
    for (int i = pREQ - 1; i >= 0; i--)
      if (pend[(int'(rr_ptr) + i) % pREQ]) gnt_id = ID_W'((int'(rr_ptr) + i) % pREQ);
    any = |pend;
    gnt = any ? pREQ'(1) << gnt_id : '0;
  end
endmodule

// File: rtl/pulse_sync_sched.sv
// pulse_sync_sched: round-robin scheduler sharing one pulse_sync channel with enforced pulse spacing
module pulse_sync_sched
  import pulse_sync_pkg::*;
#(
  parameter int pREQ = DEF_REQ,
  parameter int pCNT_W = DEF_CNT_W,
  parameter int pGAP = DEF_GAP,
  localparam int ID_W = clog2(pREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [pREQ-1:0] req_pls,
  input  logic            clr_ovf,
  output logic            out_pls,
  output logic [ID_W-1:0] out_id,
  output logic [pREQ-1:0] ovf,
  output logic            busy
);
  localparam int G_W = clog2(pGAP + 1);
  localparam logic [pCNT_W-1:0] CNT_MAX = '1;
  state_e state_q, state_d;
  logic [pCNT_W-1:0] cnt_q [pREQ];
  logic [pCNT_W-1:0] cnt_d [pREQ];
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, gnt_id;
  logic [G_W-1:0] gap_q, gap_d;
  logic [pREQ-1:0] ovf_q, ovf_d, pend, gnt;
  logic pls_q, pls_d, any, go;
  always_comb begin
    pend = '0;
    for (int i = 0; i < pREQ; i++) pend[i] = cnt_q[i] != '0;
  end
  rr_arbiter #(.pREQ(pREQ)) u_arb (
    .pend(pend),
    .rr_ptr(rr_q),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .any(any)
  );
  always_comb begin
    go = any && en && (state_q == IDLE || (state_q == GAP && gap_q == '0));
    state_d = go ? ISSUE : state_q == ISSUE ? GAP : (state_q == GAP && gap_q != '0) ? GAP : IDLE;
    id_d = go ? gnt_id : id_q;
    pls_d = go;
    rr_d = state_q == ISSUE ? (id_q == ID_W'(pREQ - 1) ? '0 : id_q + 1'b1) : rr_q;
    gap_d = state_q == ISSUE ? G_W'(pGAP - 1) : (state_q == GAP && gap_q != '0) ? gap_q - 1'b1 : gap_q;
    ovf_d = clr_ovf ? '0 : ovf_q;
    for (int i = 0; i < pREQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (req_pls[i] && !(go && gnt[i])) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!req_pls[i] && go && gnt[i]) cnt_d[i] = cnt_q[i] - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '{default: '0};
      rr_q <= '0;
      id_q <= '0;
      pls_q <= 1'b0;
      gap_q <= '0;
      ovf_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      id_q <= id_d;
      pls_q <= pls_d;
      gap_q <= gap_d;
      ovf_q <= ovf_d;
    end
  end
  assign out_pls = pls_q;
  assign out_id = id_q;
  assign ovf = ovf_q;
  assign busy = state_q != IDLE || |pend;
endmodule
